// File: rtl/counter_sequencer.sv
// counter_sequencer
//
// Purpose:
//   Button-driven 4-bit up/down counter that advances once per tick period.
//   Two raw push-buttons are synchronized and debounced; the debounced pair
//   selects the FSM state (IDLE/UP/DOWN/CONFLICT). On every TICK the count
//   moves one step in the direction of the registered state.
//
// Build option:
//   COUNTER_SATURATE_EN  defined   -> count saturates at 15 (up) and 0 (down)
//                        undefined -> count wraps 15->0 (up) and 0->15 (down)
//
// Parameters:
//   TICK_DIV   clock cycles per tick period (2 .. 2^32-1)
//   DB_CYCLES  consecutive differing cycles needed to accept a new button
//              level (1 .. 2^24-1)
//
// Ports:
//   CLOCK    in   sole clock, rising edge
//   RES_N    in   asynchronous active-low reset
//   BUTTONS  in   [0] up request, [1] down request (raw, asynchronous)
//   CLR      in   synchronous clear of count and tick divider (level)
//   LEDS     out  registered count value
//   TICK     out  one-cycle pulse per tick period (held low while CLR=1)
//   DIR      out  registered FSM state: 00 IDLE, 01 UP, 10 DOWN, 11 CONFLICT

module counter_sequencer #(
    parameter int unsigned TICK_DIV  = 62500000,
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic       CLOCK,
    input  logic       RES_N,
    input  logic [1:0] BUTTONS,
    input  logic       CLR,
    output logic [3:0] LEDS,
    output logic       TICK,
    output logic [1:0] DIR
);

    localparam logic [31:0] DIV_LAST = 32'(TICK_DIV - 1);
    localparam logic [23:0] DB_LAST  = 24'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        UP       = 2'b01,
        DOWN     = 2'b10,
        CONFLICT = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizer per button bit
    // ------------------------------------------------------------------
    logic [1:0] sync_a;
    logic [1:0] sync_b;

    always_ff @(posedge CLOCK or negedge RES_N) begin
        if (!RES_N) begin
            sync_a <= 2'b00;
            sync_b <= 2'b00;
        end else begin
            sync_a <= BUTTONS;
            sync_b <= sync_a;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: a bit's accepted level only flips once the synchronized
    // level has disagreed with it for DB_CYCLES cycles in a row. Any cycle
    // of agreement restarts that bit's run from zero.
    // ------------------------------------------------------------------
    logic [1:0]       db_level;
    logic [1:0][23:0] db_cnt;

    always_ff @(posedge CLOCK or negedge RES_N) begin
        if (!RES_N) begin
            db_level <= 2'b00;
            db_cnt   <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] != db_level[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db_level[i] <= sync_b[i];
                        db_cnt[i]   <= 24'd0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 24'd1;
                    end
                end else begin
                    db_cnt[i] <= 24'd0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Tick divider. The pulse is registered on the edge where the divider
    // wraps, so the first pulse after reset or CLR appears at the
    // TICK_DIV-th edge. CLR masks the output combinationally so that a
    // pulse already registered cannot escape during a clear cycle.
    // ------------------------------------------------------------------
    logic [31:0] div_q;
    logic        tick_q;

    always_ff @(posedge CLOCK or negedge RES_N) begin
        if (!RES_N) begin
            div_q  <= 32'd0;
            tick_q <= 1'b0;
        end else if (CLR) begin
            div_q  <= 32'd0;
            tick_q <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q  <= 32'd0;
            tick_q <= 1'b1;
        end else begin
            div_q  <= div_q + 32'd1;
            tick_q <= 1'b0;
        end
    end

    assign TICK = tick_q & ~CLR;

    // ------------------------------------------------------------------
    // Direction FSM: state follows the debounced pair {dn,up} each cycle
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;

    always_ff @(posedge CLOCK or negedge RES_N) begin
        if (!RES_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case ({db_level[1], db_level[0]})
            2'b00:   state_d = IDLE;
            2'b01:   state_d = UP;
            2'b10:   state_d = DOWN;
            default: state_d = CONFLICT;
        endcase
    end

    // ------------------------------------------------------------------
    // Count register. Uses the registered state of the tick cycle, so
    // LEDS moves on the edge that ends the TICK cycle.
    // ------------------------------------------------------------------
    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (CLR) begin
            count_d = 4'd0;
        end else if (tick_q) begin
            case (state_q)
`ifdef COUNTER_SATURATE_EN
                UP:      count_d = (count_q == 4'hF) ? count_q : count_q + 4'd1;
                DOWN:    count_d = (count_q == 4'h0) ? count_q : count_q - 4'd1;
`else
                UP:      count_d = count_q + 4'd1;
                DOWN:    count_d = count_q - 4'd1;
`endif
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RES_N) begin
        if (!RES_N) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign LEDS = count_q;
    assign DIR  = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed testbench for counter_sequencer (TICK_DIV=10, DB_CYCLES=4).
// Inputs change on the falling edge; outputs are checked on the falling
// edge (or shortly after an asynchronous input change).
module tb_counter_sequencer;

    localparam int unsigned TICK_DIV  = 10;
    localparam int unsigned DB_CYCLES = 4;

`ifdef COUNTER_SATURATE_EN
    localparam logic [3:0] UP_AT_15  = 4'd15;
    localparam logic [3:0] DOWN_AT_0 = 4'd0;
`else
    localparam logic [3:0] UP_AT_15  = 4'd0;
    localparam logic [3:0] DOWN_AT_0 = 4'd15;
`endif

    logic       CLOCK = 1'b0;
    logic       RES_N;
    logic [1:0] BUTTONS;
    logic       CLR;
    logic [3:0] LEDS;
    logic       TICK;
    logic [1:0] DIR;

    int vectors     = 0;
    int miscompares = 0;

    counter_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .CLOCK   (CLOCK),
        .RES_N   (RES_N),
        .BUTTONS (BUTTONS),
        .CLR     (CLR),
        .LEDS    (LEDS),
        .TICK    (TICK),
        .DIR     (DIR)
    );

    // ---------------- clock ----------------
    always #5 CLOCK = ~CLOCK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, got no finish expected finish");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLOCK);
        @(negedge CLOCK);
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        while (TICK !== 1'b1 && n < 15) begin
            step();
            n++;
        end
        vectors++;
        if (TICK !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: TICK=%b after %0d cycles, expected 1", name, TICK, n);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RES_N = 1'b0; BUTTONS = 2'b00; CLR = 1'b0;
        #2;
        vectors++; if (LEDS !== 4'd0) begin miscompares++; $display("FAIL reset_leds: got %0d expected 0", LEDS); end
        vectors++; if (TICK !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b expected 0", TICK); end
        vectors++; if (DIR !== 2'b00) begin miscompares++; $display("FAIL reset_dir: got %b expected 00", DIR); end
        @(negedge CLOCK);
        @(negedge CLOCK);
        vectors++; if (LEDS !== 4'd0 || DIR !== 2'b00 || TICK !== 1'b0) begin
            miscompares++; $display("FAIL reset_hold: got leds=%0d dir=%b tick=%b expected 0/00/0", LEDS, DIR, TICK);
        end
    endtask

    task automatic test_idle();
        RES_N = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            logic exp_tick;
            exp_tick = (k % 10 == 0);
            step();
            vectors++; if (TICK !== exp_tick) begin miscompares++; $display("FAIL idle_tick@%0d: got %b expected %b", k, TICK, exp_tick); end
            vectors++; if (LEDS !== 4'd0) begin miscompares++; $display("FAIL idle_leds@%0d: got %0d expected 0", k, LEDS); end
            vectors++; if (DIR !== 2'b00) begin miscompares++; $display("FAIL idle_dir@%0d: got %b expected 00", k, DIR); end
        end
    endtask

    task automatic test_up();
        BUTTONS = 2'b01;
        repeat (6) step();
        vectors++; if (DIR !== 2'b00) begin miscompares++; $display("FAIL up_early: got %b expected 00", DIR); end
        step();
        vectors++; if (DIR !== 2'b01) begin miscompares++; $display("FAIL up_dir: got %b expected 01", DIR); end
        for (int i = 1; i <= 15; i++) begin
            wait_tick("up_wait");
            step();
            vectors++; if (LEDS !== 4'(i)) begin miscompares++; $display("FAIL up_count: got %0d expected %0d", LEDS, i); end
        end
    endtask

    task automatic test_wrap_up();
        wait_tick("wrap_up_wait");
        step();
        vectors++; if (LEDS !== UP_AT_15) begin miscompares++; $display("FAIL wrap_up: got %0d expected %0d", LEDS, UP_AT_15); end
    endtask

    task automatic test_wrap_down();
        CLR = 1'b1; BUTTONS = 2'b10;
        for (int k = 1; k <= 7; k++) begin
            step();
            vectors++; if (TICK !== 1'b0) begin miscompares++; $display("FAIL clr_held_tick@%0d: got %b expected 0", k, TICK); end
        end
        vectors++; if (DIR !== 2'b10) begin miscompares++; $display("FAIL down_dir: got %b expected 10", DIR); end
        vectors++; if (LEDS !== 4'd0) begin miscompares++; $display("FAIL clr_leds: got %0d expected 0", LEDS); end
        CLR = 1'b0;
        wait_tick("wrap_down_wait");
        vectors++; if (LEDS !== 4'd0) begin miscompares++; $display("FAIL down_pre: got %0d expected 0", LEDS); end
        step();
        vectors++; if (LEDS !== DOWN_AT_0) begin miscompares++; $display("FAIL wrap_down: got %0d expected %0d", LEDS, DOWN_AT_0); end
    endtask

    task automatic test_conflict();
        CLR = 1'b1; BUTTONS = 2'b11;
        repeat (7) step();
        vectors++; if (DIR !== 2'b11) begin miscompares++; $display("FAIL conflict_dir: got %b expected 11", DIR); end
        CLR = 1'b0;
        for (int t = 0; t < 5; t++) begin
            wait_tick("conflict_wait");
            step();
            vectors++; if (LEDS !== 4'd0 || DIR !== 2'b11) begin
                miscompares++; $display("FAIL conflict_hold: got leds=%0d dir=%b expected 0/11", LEDS, DIR);
            end
        end
    endtask

    task automatic test_bounce();
        CLR = 1'b1; BUTTONS = 2'b00;
        repeat (7) step();
        vectors++; if (DIR !== 2'b00) begin miscompares++; $display("FAIL release_dir: got %b expected 00", DIR); end
        CLR = 1'b0;
        for (int c = 0; c < 40; c++) begin
            logic [5:0] cc;
            cc = 6'(c);
            BUTTONS = {1'b0, cc[1]};
            step();
            vectors++; if (DIR !== 2'b00 || LEDS !== 4'd0) begin
                miscompares++; $display("FAIL bounce@%0d: got dir=%b leds=%0d expected 00/0", c, DIR, LEDS);
            end
        end
        BUTTONS = 2'b00;
        repeat (6) step();
        vectors++; if (DIR !== 2'b00) begin miscompares++; $display("FAIL bounce_settle: got %b expected 00", DIR); end
    endtask

    task automatic test_clr_on_tick();
        BUTTONS = 2'b01;
        repeat (7) step();
        vectors++; if (DIR !== 2'b01) begin miscompares++; $display("FAIL up2_dir: got %b expected 01", DIR); end
        wait_tick("up2_wait");
        step();
        vectors++; if (LEDS !== 4'd1) begin miscompares++; $display("FAIL up2_count: got %0d expected 1", LEDS); end
        wait_tick("clr_tick_wait");
        CLR = 1'b1;
        #1;
        vectors++; if (TICK !== 1'b0) begin miscompares++; $display("FAIL clr_tick_mask: got %b expected 0", TICK); end
        step();
        CLR = 1'b0;
        vectors++; if (LEDS !== 4'd0) begin miscompares++; $display("FAIL clr_override: got %0d expected 0", LEDS); end
        for (int k = 1; k <= 10; k++) begin
            logic exp_tick;
            exp_tick = (k == 10);
            step();
            vectors++; if (TICK !== exp_tick) begin miscompares++; $display("FAIL clr_next_tick@%0d: got %b expected %b", k, TICK, exp_tick); end
        end
        step();
        vectors++; if (LEDS !== 4'd1) begin miscompares++; $display("FAIL clr_resume: got %0d expected 1", LEDS); end
    endtask

    task automatic test_reset_mid();
        for (int i = 2; i <= 7; i++) begin
            wait_tick("rst_fill_wait");
            step();
            vectors++; if (LEDS !== 4'(i)) begin miscompares++; $display("FAIL rst_fill: got %0d expected %0d", LEDS, i); end
        end
        repeat (3) step();
        vectors++; if (LEDS !== 4'd7 || DIR !== 2'b01) begin
            miscompares++; $display("FAIL rst_pre: got leds=%0d dir=%b expected 7/01", LEDS, DIR);
        end
        #2 RES_N = 1'b0;
        #1;
        vectors++; if (LEDS !== 4'd0) begin miscompares++; $display("FAIL rst_async_leds: got %0d expected 0", LEDS); end
        vectors++; if (DIR !== 2'b00) begin miscompares++; $display("FAIL rst_async_dir: got %b expected 00", DIR); end
        vectors++; if (TICK !== 1'b0) begin miscompares++; $display("FAIL rst_async_tick: got %b expected 0", TICK); end
        @(negedge CLOCK);
        @(negedge CLOCK);
        RES_N = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            logic [3:0] exp_leds;
            logic       exp_tick;
            logic [1:0] exp_dir;
            exp_leds = (k == 11) ? 4'd1 : 4'd0;
            exp_tick = (k == 10);
            exp_dir  = (k >= 7) ? 2'b01 : 2'b00;
            step();
            vectors++; if (LEDS !== exp_leds) begin miscompares++; $display("FAIL post_rst_leds@%0d: got %0d expected %0d", k, LEDS, exp_leds); end
            vectors++; if (TICK !== exp_tick) begin miscompares++; $display("FAIL post_rst_tick@%0d: got %b expected %b", k, TICK, exp_tick); end
            vectors++; if (DIR !== exp_dir) begin miscompares++; $display("FAIL post_rst_dir@%0d: got %b expected %b", k, DIR, exp_dir); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_idle();
        test_up();
        test_wrap_up();
        test_wrap_down();
        test_conflict();
        test_bounce();
        test_clr_on_tick();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 62500000, count period in CLOCK cycles between TICK pulses (legal range 2 to 2^32-1).
REQ-002 Parameter DB_CYCLES, default 1000000, consecutive stable cycles required to accept a new button level (legal range 1 to 2^24-1).
REQ-003 CLOCK  input  1  sole clock; all state rising-edge triggered.
REQ-004 RES_N  input  1  asynchronous, active-low reset.
REQ-005 BUTTONS  input  2  raw asynchronous push-buttons; [0]=up request, [1]=down request.
REQ-006 CLR  input  1  synchronous clear request, level-sensitive, CLOCK domain.
REQ-007 LEDS  output  4  current count value.
REQ-008 TICK  output  1  single-cycle pulse marking each count period.
REQ-009 DIR  output  2  FSM state encoding: 00 IDLE, 01 UP, 10 DOWN, 11 CONFLICT.

Function
REQ-010 Each BUTTONS bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Per bit, the debounced level SHALL update only after the synchronized level differs from it for DB_CYCLES consecutive cycles; any return to the debounced level SHALL reset that bit's stability counter to 0.
REQ-012 Tick divider SHALL count 0..TICK_DIV-1 and assert TICK for exactly one cycle when the count equals TICK_DIV-1, then wrap to 0.
REQ-013 FSM SHALL update every cycle from the debounced pair {dn,up}: 00->IDLE, 01->UP, 10->DOWN, 11->CONFLICT; any state reaches any other in one cycle.
REQ-014 On a cycle with TICK=1 and CLR=0: UP -> count+1; DOWN -> count-1; IDLE and CONFLICT -> count held.
REQ-015 The FSM state used in REQ-014 SHALL be the registered state in the same cycle as TICK, so LEDS changes on the clock edge following the TICK cycle.
REQ-016 Count arithmetic SHALL be 4-bit unsigned; overflow/underflow behaviour per REQ-024/REQ-025.
REQ-017 CLR=1 SHALL set count to 0 and the tick divider to 0 on the next edge, overriding any simultaneous TICK; TICK SHALL stay 0 while CLR=1.
REQ-018 After CLR deasserts, the first TICK SHALL occur TICK_DIV cycles after the last CLR=1 edge.
REQ-019 DIR SHALL equal the registered FSM state; LEDS SHALL equal the registered count; both glitch-free register outputs.

Reset
REQ-020 RES_N=0 SHALL immediately force count=0, LEDS=0, TICK=0, DIR=00 (IDLE), tick divider=0, synchronizers=0, debounced levels=0, stability counters=0.
REQ-021 Reset assertion mid-debounce or mid-period SHALL discard all partial progress; no pending count update survives reset.
REQ-022 Reset deassertion is synchronized externally; after release the first TICK SHALL occur at the TICK_DIV-th rising edge.
REQ-023 Buttons held through reset release SHALL be accepted only after full synchronizer plus DB_CYCLES qualification.

Configuration
REQ-024 With macro COUNTER_SATURATE_EN defined: UP at count 15 SHALL hold 15; DOWN at count 0 SHALL hold 0.
REQ-025 Without COUNTER_SATURATE_EN: UP at 15 SHALL wrap to 0; DOWN at 0 SHALL wrap to 15.

Verification (TICK_DIV=10, DB_CYCLES=4)
REQ-026 Reset, BUTTONS=00 for 100 cycles -> TICK pulses every 10 cycles, LEDS=0, DIR=00 throughout.
REQ-027 BUTTONS=01 held -> DIR=01 at 2+4+1 cycles after the edge; LEDS increments by 1 after each subsequent TICK; reaches 3 after 3 ticks.
REQ-028 BUTTONS[0] toggling every 2 cycles for 40 cycles -> DIR stays 00, LEDS unchanged (bounce rejected).
REQ-029 LEDS=15, BUTTONS=01, one TICK -> LEDS=0 without macro, LEDS=15 with COUNTER_SATURATE_EN; LEDS=0, BUTTONS=10 -> 15 / 0 respectively.
REQ-030 BUTTONS=11 held -> DIR=11, LEDS constant across 5 ticks; CLR pulsed on a TICK cycle with DIR=01 -> LEDS=0, no TICK that cycle, next TICK 10 cycles after CLR.
REQ-031 RES_N pulsed low mid-period with LEDS=7 and DIR=01 -> outputs zero asynchronously; after release LEDS stays 0 until buttons requalify.
